// File: rtl/apb_slave_regfile.sv
// APB3 completer exposing NUM_REGS word registers, optional read-only slots
// fed from ro_data, configurable wait states and a post-commit write strobe.
module apb_slave_regfile #(
  parameter int                        APB_ADDR_WIDTH = 16,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        NUM_REGS       = 16,
  parameter int                        WAIT_CYCLES    = 0,
  parameter logic [NUM_REGS-1:0]       RO_MASK        = '0,
  parameter logic [APB_DATA_WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic                               pclk,
  input  logic                               preset,
  input  logic                               psel,
  input  logic                               penable,
  input  logic [APB_ADDR_WIDTH-1:0]          paddr,
  input  logic                               pwrite,
  input  logic [APB_DATA_WIDTH-1:0]          pwdata,
  output logic [APB_DATA_WIDTH-1:0]          prdata,
  output logic                               pready,
  output logic                               pslverr,
  input  logic [NUM_REGS*APB_DATA_WIDTH-1:0] ro_data,
  output logic [NUM_REGS*APB_DATA_WIDTH-1:0] regs_q,
  output logic                               wr_pulse,
  output logic [7:0]                         wr_idx
);

  localparam int DW     = APB_DATA_WIDTH;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int FULL_W = APB_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [DW-1:0]     r_wdata;
  logic              r_err;
  logic [3:0]        r_cnt;
  logic [DW-1:0]     r_regs [NUM_REGS];

  logic [DW-1:0]     r_prdata;
  logic              r_pready;
  logic              r_pslverr;
  logic              r_wr_pulse;
  logic [7:0]        r_wr_idx;

  logic [FULL_W-1:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_err;
  logic              w_setup;
  logic              w_access;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_sel_write;
  logic              w_sel_err;
  logic [DW-1:0]     w_rd_val;
  logic              w_unused_addr_lsbs;

  assign w_idx_full         = paddr[APB_ADDR_WIDTH-1:2];
  assign w_idx              = w_idx_full[IDX_W-1:0];
  assign w_in_range         = (w_idx_full < FULL_W'(NUM_REGS));
  assign w_err              = w_in_range ? (pwrite & RO_MASK[w_idx]) : 1'b1;
  assign w_setup            = psel & ~penable;
  assign w_access           = psel & penable;
  assign w_unused_addr_lsbs = ^paddr[1:0];

  // Entering READY straight from IDLE must use the live decode; from WAIT the latched copy.
  assign w_sel_idx   = (r_state == S_IDLE) ? w_idx  : r_idx;
  assign w_sel_write = (r_state == S_IDLE) ? pwrite : r_write;
  assign w_sel_err   = (r_state == S_IDLE) ? w_err  : r_err;
  assign w_rd_val    = RO_MASK[w_sel_idx] ? ro_data[int'(w_sel_idx)*DW +: DW]
                                          : r_regs[w_sel_idx];

  always_ff @(posedge pclk) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_setup) w_next_state = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
      S_WAIT: begin
        if (!psel)                              w_next_state = S_IDLE;
        else if (penable && (r_cnt == 4'd1))    w_next_state = S_READY;
      end
      S_READY: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: the register array is flop-based and needs a defined RESET_VAL, so it is reset
  // in the same block as the control state rather than inferred as a RAM.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_prdata   <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_idx   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      if ((r_state == S_IDLE) && w_setup) begin
        r_idx   <= w_idx;
        r_write <= pwrite;
        r_wdata <= pwdata;
        r_err   <= w_err;
        if (WAIT_CYCLES != 0) r_cnt <= 4'(WAIT_CYCLES);
      end
      if ((r_state == S_WAIT) && w_access && (r_cnt != 4'd1)) r_cnt <= r_cnt - 4'd1;

      r_pready  <= (w_next_state == S_READY);
      r_pslverr <= (w_next_state == S_READY) & w_sel_err;
      r_prdata  <= ((w_next_state == S_READY) && !w_sel_write && !w_sel_err) ? w_rd_val : '0;

      r_wr_pulse <= 1'b0;
      if ((r_state == S_READY) && r_write && !r_err) begin
        r_regs[r_idx] <= r_wdata;
        r_wr_pulse    <= 1'b1;
        r_wr_idx      <= 8'(r_idx);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_q
    assign regs_q[gi*DW +: DW] = RO_MASK[gi] ? '0 : r_regs[gi];
  end

  assign prdata   = r_prdata;
  assign pready   = r_pready;
  assign pslverr  = r_pslverr;
  assign wr_pulse = r_wr_pulse;
  assign wr_idx   = r_wr_idx;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a zero-wait instance and a 3-wait instance
// share the bus wires and are selected through separate psel lines.
module tb_apb_slave_regfile;

  localparam int              AW  = 16;
  localparam int              DW  = 32;
  localparam int              NR  = 16;
  localparam logic [DW-1:0]   RST = 32'hA5A5_0000;
  localparam logic [NR-1:0]   ROM = 16'h0004;
  localparam logic [DW-1:0]   RO2 = 32'h1234_5678;

  logic              pclk = 1'b0;
  logic              preset;
  logic              psel0, psel1, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [NR*DW-1:0]  ro_data;

  logic [DW-1:0]     prdata0, prdata1;
  logic              pready0, pready1, pslverr0, pslverr1, wr_pulse0, wr_pulse1;
  logic [NR*DW-1:0]  regs_q0, regs_q1;
  logic [7:0]        wr_idx0, wr_idx1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  apb_slave_regfile #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REGS(NR),
    .WAIT_CYCLES(0), .RO_MASK(ROM), .RESET_VAL(RST)
  ) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .ro_data(ro_data), .regs_q(regs_q0),
    .wr_pulse(wr_pulse0), .wr_idx(wr_idx0)
  );

  apb_slave_regfile #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REGS(NR),
    .WAIT_CYCLES(3), .RO_MASK(ROM), .RESET_VAL(RST)
  ) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata1),
    .pready(pready1), .pslverr(pslverr1), .ro_data(ro_data), .regs_q(regs_q1),
    .wr_pulse(wr_pulse1), .wr_idx(wr_idx1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] slot(input logic [NR*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic pready_of(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    tick(); tick();
    preset = 1'b0;
  endtask

  task automatic idle();
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    tick();
  endtask

  // Full APB transfer; pwdata is inverted during the access phase to prove it is ignored.
  task automatic apb_xfer(input int d, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                          output logic err, output int acc, output logic [DW-1:0] pre_slot);
    bit done;
    if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
    penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    tick();
    penable = 1'b1; pwdata = ~wdata;
    acc = 0; done = 1'b0;
    while (!done) begin
      acc++;
      if (pready_of(d)) done = 1'b1;
      else if (acc > 40) begin
        check("xfer_timeout_pready", 32'(pready_of(d)), 32'd1);
        done = 1'b1;
      end else tick();
    end
    rdata    = (d == 0) ? prdata0 : prdata1;
    err      = (d == 0) ? pslverr0 : pslverr1;
    pre_slot = slot((d == 0) ? regs_q0 : regs_q1, int'(addr[AW-1:2]) % NR);
    tick();
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd, pre;
    logic          err;
    int            acc;
    logic          seen;

    for (int i = 0; i < NR; i++)
      ro_data[i*DW +: DW] = (i == 2) ? RO2 : (32'hBAD0_0000 | 32'(i));
    paddr = '0; pwrite = 1'b0; pwdata = '0;

    // Reset state
    do_reset();
    check("rst_pready",   32'(pready0),   32'd0);
    check("rst_pslverr",  32'(pslverr0),  32'd0);
    check("rst_prdata",   prdata0,        32'd0);
    check("rst_wr_pulse", 32'(wr_pulse0), 32'd0);
    check("rst_wr_idx",   32'(wr_idx0),   32'd0);
    for (int i = 0; i < NR; i++)
      check($sformatf("rst_regs_q%0d", i), slot(regs_q0, i), (i == 2) ? 32'd0 : RST);

    // Read every index back-to-back, zero wait states
    for (int i = 0; i < NR; i++) begin
      apb_xfer(0, 1'b0, AW'(i*4), 32'd0, rd, err, acc, pre);
      check($sformatf("rd%0d_data", i), rd, (i == 2) ? RO2 : RST);
      check($sformatf("rd%0d_err", i), 32'(err), 32'd0);
      check($sformatf("rd%0d_cycles", i), 32'(acc), 32'd1);
    end
    idle();
    check("idle_pready", 32'(pready0), 32'd0);
    check("idle_prdata", prdata0,      32'd0);

    // Write idx 3 then read it back with no idle cycle
    apb_xfer(0, 1'b1, 16'h000C, 32'hDEAD_BEEF, rd, err, acc, pre);
    check("wr3_err",      32'(err),       32'd0);
    check("wr3_prdata",   rd,             32'd0);
    check("wr3_pulse",    32'(wr_pulse0), 32'd1);
    check("wr3_idx",      32'(wr_idx0),   32'd3);
    check("wr3_regs_q",   slot(regs_q0, 3), 32'hDEAD_BEEF);
    apb_xfer(0, 1'b0, 16'h000C, 32'd0, rd, err, acc, pre);
    check("rb3_data",     rd,             32'hDEAD_BEEF);
    check("rb3_pulse_gone", 32'(wr_pulse0), 32'd0);
    apb_xfer(0, 1'b0, 16'h000F, 32'd0, rd, err, acc, pre);
    check("rb3_lsbs_ignored", rd,         32'hDEAD_BEEF);

    // Read-only slot 2
    apb_xfer(0, 1'b0, 16'h0008, 32'd0, rd, err, acc, pre);
    check("ro_rd_data",   rd,             RO2);
    check("ro_rd_err",    32'(err),       32'd0);
    apb_xfer(0, 1'b1, 16'h0008, 32'h0000_0055, rd, err, acc, pre);
    check("ro_wr_err",    32'(err),       32'd1);
    check("ro_wr_prdata", rd,             32'd0);
    check("ro_wr_pulse",  32'(wr_pulse0), 32'd0);
    apb_xfer(0, 1'b0, 16'h0008, 32'd0, rd, err, acc, pre);
    check("ro_reread",    rd,             RO2);
    check("ro_regs_q",    slot(regs_q0, 2), 32'd0);

    // Out-of-range index 16
    apb_xfer(0, 1'b0, 16'h0040, 32'd0, rd, err, acc, pre);
    check("oor_rd_err",   32'(err),       32'd1);
    check("oor_rd_data",  rd,             32'd0);
    apb_xfer(0, 1'b1, 16'h0040, 32'h1111_1111, rd, err, acc, pre);
    check("oor_wr_err",   32'(err),       32'd1);
    check("oor_wr_pulse", 32'(wr_pulse0), 32'd0);
    check("oor_slot0",    slot(regs_q0, 0), RST);
    check("oor_slot3",    slot(regs_q0, 3), 32'hDEAD_BEEF);

    // Access phase without setup is ignored in IDLE
    psel0 = 1'b1; penable = 1'b1; paddr = 16'h0004; pwrite = 1'b0;
    tick();
    check("nosetup_pready_a", 32'(pready0), 32'd0);
    tick();
    check("nosetup_pready_b", 32'(pready0), 32'd0);
    idle();

    // Three wait states: write idx 5
    apb_xfer(1, 1'b1, 16'h0014, 32'hCAFE_F00D, rd, err, acc, pre);
    check("w3_cycles",    32'(acc),       32'd4);
    check("w3_err",       32'(err),       32'd0);
    check("w3_not_early", pre,            RST);
    check("w3_pulse",     32'(wr_pulse1), 32'd1);
    check("w3_idx",       32'(wr_idx1),   32'd5);
    check("w3_regs_q",    slot(regs_q1, 5), 32'hCAFE_F00D);
    apb_xfer(1, 1'b0, 16'h0014, 32'd0, rd, err, acc, pre);
    check("w3_rb_data",   rd,             32'hCAFE_F00D);
    check("w3_rb_cycles", 32'(acc),       32'd4);

    // Reset asserted in the second WAIT cycle of a write to idx 1
    psel1 = 1'b1; penable = 1'b0; paddr = 16'h0004; pwrite = 1'b1; pwdata = 32'h0BAD_F00D;
    tick();
    penable = 1'b1;
    tick();
    preset = 1'b1;
    tick();
    preset = 1'b0; psel1 = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen = seen | pready1 | wr_pulse1;
      tick();
    end
    check("mid_rst_no_ready_or_pulse", 32'(seen), 32'd0);
    check("mid_rst_reg1", slot(regs_q1, 1), RST);
    check("mid_rst_reg5", slot(regs_q1, 5), RST);
    apb_xfer(1, 1'b0, 16'h0004, 32'd0, rd, err, acc, pre);
    check("mid_rst_rd1",  rd,             RST);
    check("mid_rst_rd1_cycles", 32'(acc), 32'd4);

    // psel dropped during WAIT aborts the transfer
    psel1 = 1'b1; penable = 1'b0; paddr = 16'h001C; pwrite = 1'b1; pwdata = 32'h0000_0077;
    tick();
    penable = 1'b1;
    tick();
    psel1 = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen = seen | pready1 | pslverr1 | wr_pulse1;
      tick();
    end
    check("abort_no_ready", 32'(seen),    32'd0);
    check("abort_reg7",   slot(regs_q1, 7), RST);
    apb_xfer(1, 1'b0, 16'h001C, 32'd0, rd, err, acc, pre);
    check("abort_rd7",    rd,             RST);
    check("abort_rd7_cycles", 32'(acc),   32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3 completer (slave) RTL block. It is the responder end of the APB bus driven by the APB master VIP.
- Implements NUM_REGS word registers with a configurable number of wait states.
- Flags bad accesses with pslverr: out-of-range index, or a write to a read-only slot.
- Serves as the DUT-side APB endpoint in the dtc_prj environment. It exposes the register contents and a write strobe to downstream logic.

Parameters:
APB_ADDR_WIDTH, 16, paddr width
APB_DATA_WIDTH, 32, pwdata/prdata width
NUM_REGS, 16, number of word registers (2..256)
WAIT_CYCLES, 0, pready-low cycles inserted per access (0..15)
RO_MASK, 'h0, NUM_REGS bits; bit i=1 makes reg i read-only (value taken from ro_data)
RESET_VAL, 'h0, reset value of every RW register

Ports:
pclk  input  1  clock, all logic on rising edge
preset  input  1  synchronous active-high reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
paddr  input  APB_ADDR_WIDTH  byte address
pwrite  input  1  1=write, 0=read
pwdata  input  APB_DATA_WIDTH  write data
prdata  output  APB_DATA_WIDTH  read data, valid only when pready=1
pready  output  1  transfer complete
pslverr  output  1  error, valid only when pready=1
ro_data  input  NUM_REGS*APB_DATA_WIDTH  read-only register sources, slot i at [i*W +: W]
regs_q  output  NUM_REGS*APB_DATA_WIDTH  current register contents; RO slots read 0
wr_pulse  output  1  one-cycle strobe after a committed write
wr_idx  output  8  index of the committed write

Behaviour:
- Reset (preset=1 at a pclk edge):
  - state=IDLE, pready=0, pslverr=0, prdata=0, wr_pulse=0, wr_idx=0.
  - All RW regs = RESET_VAL.
  - Applies mid-transfer: the pending access is dropped and no write occurs.
- Decode:
  - idx = paddr[APB_ADDR_WIDTH-1:2]; paddr[1:0] ignored.
  - err = (idx >= NUM_REGS) | (pwrite & RO_MASK[idx]).
  - RO_MASK is evaluated only when idx < NUM_REGS.
- FSM states: IDLE, WAIT, READY. All outputs are registered.
- IDLE:
  - On psel=1 & penable=0 (setup phase), latch idx, pwrite, pwdata and err.
  - If WAIT_CYCLES=0, go to READY. Otherwise load cnt=WAIT_CYCLES and go to WAIT.
  - psel=1 & penable=1 seen in IDLE (no setup) is ignored; state stays IDLE.
- WAIT:
  - pready=0. cnt decrements each cycle with psel & penable = 1.
  - When cnt==1 and psel & penable = 1, go to READY.
  - If psel drops, abort: go to IDLE, no write, no error.
- READY:
  - pready=1 for exactly one cycle.
  - pslverr = latched err.
  - For a read with no error, prdata = reg[idx], or ro_data slot idx if RO. Sampled on the edge entering READY.
  - For a write, or on error, prdata=0.
  - Write commit happens at the end of READY when the write has no error: reg[idx] <= latched pwdata.
  - Next state is IDLE.
- Latency:
  - Access phase lasts WAIT_CYCLES+1 cycles.
  - Minimum transfer is 2 cycles (setup + access).
  - Back-to-back transfers with no idle cycle are supported: the setup phase that follows READY is accepted in IDLE.
- Commit side effects:
  - The cycle after a write commit: wr_pulse=1 and wr_idx=idx; regs_q already shows the new value.
  - Error writes never pulse and never modify any register.
- Outside READY: pready=0, pslverr=0, prdata=0.
- Read-during-write: a read of the register written by the immediately preceding transfer returns the new value.
- pwdata changes during WAIT are ignored; the setup-phase value is used.
- cnt is 4 bits wide and never wraps. It is only loaded when WAIT_CYCLES>0.

Test Plan:
- Reset, then read every index with WAIT_CYCLES=0 -> each access takes 2 cycles, prdata=RESET_VAL, pslverr=0; regs_q=all RESET_VAL.
- Write idx 3 (paddr=0x000C) with 0xDEADBEEF, then read it back-to-back -> wr_pulse one cycle with wr_idx=3, regs_q slot 3=0xDEADBEEF, read prdata=0xDEADBEEF.
- Set WAIT_CYCLES=3 and write idx 5 -> pready low for 3 access cycles and high on the 4th; the write lands only after that cycle.
- Set RO_MASK bit 2=1 and ro_data slot2=0x12345678. Read paddr 0x0008 -> prdata=0x12345678, pslverr=0. Write 0x0008 -> pslverr=1, no wr_pulse, and a re-read still gives 0x12345678.
- Access paddr=0x0040 (idx 16, NUM_REGS=16) for both read and write -> pslverr=1, prdata=0, no register changes.
- Set WAIT_CYCLES=3, start a write to idx 1, and assert preset in the 2nd WAIT cycle -> FSM returns to IDLE, reg1=RESET_VAL, no wr_pulse. Separately, drop psel in WAIT -> abort with pready never asserted.
